// File: rtl/amt_pkg.sv
// Shared helpers for the architectural map table (AMT).
// - amtState_e : recovery walk states.
// - log2       : index width for a count, never less than 1 bit.
// - laneLsb    : LSB offset of lane 'lane' in a flat bus of w-bit lanes.
// - numGroups  : number of recovery cycles for n entries at rw per cycle.
package amt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } amtState_e;

  function automatic int log2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int laneLsb(input int lane, input int w);
    return lane * w;
  endfunction

  function automatic int numGroups(input int n, input int rw);
    return (n + rw - 1) / rw;
  endfunction

endpackage

// File: rtl/arch_map_table_param_if.sv
// Commit / release / recovery bus of the AMT.
// master : ActiveList side (drives commits and recoverReq_i).
// slave  : the AMT (drives release and recovery streams).
// Flat buses pack lane k at bits [k*W +: W].
interface arch_map_table_param_if #(
  parameter int COMMIT_WIDTH  = 4,
  parameter int NUM_LOG_REGS  = 34,
  parameter int PHYS_W        = 7,
  parameter int RECOVER_WIDTH = 4
);
  localparam int LOG_W = amt_pkg::log2(NUM_LOG_REGS);

  logic [COMMIT_WIDTH-1:0]         commitValid_i;
  logic [COMMIT_WIDTH*LOG_W-1:0]   commitLog_i;
  logic [COMMIT_WIDTH*PHYS_W-1:0]  commitPhys_i;
  logic                            recoverReq_i;
  logic [COMMIT_WIDTH-1:0]         releasedValid_o;
  logic [COMMIT_WIDTH*PHYS_W-1:0]  releasedPhys_o;
  logic                            recoverBusy_o;
  logic [RECOVER_WIDTH-1:0]        recoverValid_o;
  logic [RECOVER_WIDTH*LOG_W-1:0]  recoverLog_o;
  logic [RECOVER_WIDTH*PHYS_W-1:0] recoverPhys_o;
  logic                            recoverDone_o;
  logic                            commitDropped_o;

  modport master (
    output commitValid_i, commitLog_i, commitPhys_i, recoverReq_i,
    input  releasedValid_o, releasedPhys_o, recoverBusy_o, recoverValid_o,
           recoverLog_o, recoverPhys_o, recoverDone_o, commitDropped_o
  );

  modport slave (
    input  commitValid_i, commitLog_i, commitPhys_i, recoverReq_i,
    output releasedValid_o, releasedPhys_o, recoverBusy_o, recoverValid_o,
           recoverLog_o, recoverPhys_o, recoverDone_o, commitDropped_o
  );
endinterface

// File: rtl/amt_waw_squash.sv
// Write-after-write squash within one commit group (combinational).
// Lane k is squashed when it is valid and a younger valid lane j > k
// targets the same logical register; only the youngest write survives.
//   commitValid : per-lane valid
//   commitLog   : flat logical destinations, LOG_W bits per lane
//   squash      : per-lane squash flag
module amt_waw_squash
  import amt_pkg::*;
#(
  parameter int COMMIT_WIDTH = 4,
  parameter int LOG_W        = 6
) (
  input  logic [COMMIT_WIDTH-1:0]       commitValid,
  input  logic [COMMIT_WIDTH*LOG_W-1:0] commitLog,
  output logic [COMMIT_WIDTH-1:0]       squash
);

  always_comb begin
    squash = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      for (int j = k + 1; j < COMMIT_WIDTH; j++) begin
        if (commitValid[k] && commitValid[j] &&
            commitLog[laneLsb(k, LOG_W) +: LOG_W] == commitLog[laneLsb(j, LOG_W) +: LOG_W])
          squash[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arch_map_table_param.sv
// Parametrised architectural map table.
// Commit (IDLE only): records the youngest logical->physical mapping per
// logical register and returns the superseded tag one cycle later.
// Recovery: on recoverReq_i walks the table RECOVER_WIDTH entries per
// cycle (busy), then pulses done for one cycle.
//   clk, reset (async, active low)
//   amtIf : slave side of arch_map_table_param_if
module arch_map_table_param
  import amt_pkg::*;
#(
  parameter int COMMIT_WIDTH  = 4,
  parameter int NUM_LOG_REGS  = 34,
  parameter int PHYS_W        = 7,
  parameter int RECOVER_WIDTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  arch_map_table_param_if.slave amtIf
);

  localparam int LOG_W = log2(NUM_LOG_REGS);
  // Wide enough for the pointer one group past the last entry.
  localparam int PTR_W = log2(NUM_LOG_REGS + RECOVER_WIDTH + 1);

  amtState_e state, nextState;
  logic [PTR_W-1:0] ptr, nextPtr;

  logic [NUM_LOG_REGS-1:0][PHYS_W-1:0]  tbl;
  logic [COMMIT_WIDTH-1:0]              squash, inRange, wrEn;
  logic [COMMIT_WIDTH-1:0][LOG_W-1:0]   cLog;
  logic [COMMIT_WIDTH-1:0][PHYS_W-1:0]  cPhys, rdPhys, relPhysD, relPhysQ;
  logic [COMMIT_WIDTH-1:0]              relValidQ;
  logic                                 droppedQ;
  logic                                 commitEn;

  logic [RECOVER_WIDTH-1:0]             recValid;
  logic [RECOVER_WIDTH-1:0][LOG_W-1:0]  recLog;
  logic [RECOVER_WIDTH-1:0][PHYS_W-1:0] recPhys;

  assign commitEn = (state == IDLE);

  amt_waw_squash #(
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .LOG_W       (LOG_W)
  ) uSquash (
    .commitValid(amtIf.commitValid_i),
    .commitLog  (amtIf.commitLog_i),
    .squash     (squash)
  );

  // Per commit lane: read the old mapping before this cycle's writes.
  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : gLane
    assign cLog[k]    = amtIf.commitLog_i[laneLsb(k, LOG_W) +: LOG_W];
    assign cPhys[k]   = amtIf.commitPhys_i[laneLsb(k, PHYS_W) +: PHYS_W];
    assign inRange[k] = int'(cLog[k]) < NUM_LOG_REGS;
    assign rdPhys[k]  = inRange[k] ? tbl[cLog[k]] : '0;
    // A squashed lane never reached the table, so it frees its own tag.
    assign relPhysD[k] = !amtIf.commitValid_i[k] ? '0 :
                         squash[k]               ? cPhys[k] : rdPhys[k];
    assign wrEn[k] = commitEn && amtIf.commitValid_i[k] && !squash[k] && inRange[k];
  end

  // Surviving write addresses are unique, so lane order does not matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LOG_REGS; i++) tbl[i] <= PHYS_W'(i);
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (wrEn[k]) tbl[cLog[k]] <= cPhys[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      relValidQ <= '0;
      relPhysQ  <= '0;
      droppedQ  <= 1'b0;
    end else begin
      relValidQ <= commitEn ? amtIf.commitValid_i : '0;
      relPhysQ  <= commitEn ? relPhysD : '0;
      droppedQ  <= !commitEn && (|amtIf.commitValid_i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= nextState;
      ptr   <= nextPtr;
    end
  end

  always_comb begin
    nextState = state;
    nextPtr   = ptr;
    unique case (state)
      IDLE: if (amtIf.recoverReq_i) begin
        nextState = WALK;
        nextPtr   = '0;
      end
      WALK: begin
        nextPtr = ptr + PTR_W'(RECOVER_WIDTH);
        if (int'(ptr) + RECOVER_WIDTH >= NUM_LOG_REGS) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Recovery lanes read the table directly; lanes past the last entry of a
  // partial final group are invalid and driven to zero.
  for (genvar r = 0; r < RECOVER_WIDTH; r++) begin : gRec
    logic [31:0] idx;
    assign idx         = 32'(ptr) + 32'(r);
    assign recValid[r] = (state == WALK) && (idx < 32'(NUM_LOG_REGS));
    assign recLog[r]   = recValid[r] ? LOG_W'(idx) : '0;
    assign recPhys[r]  = recValid[r] ? tbl[LOG_W'(idx)] : '0;
  end

  assign amtIf.releasedValid_o = relValidQ;
  assign amtIf.releasedPhys_o  = relPhysQ;
  assign amtIf.commitDropped_o = droppedQ;
  assign amtIf.recoverBusy_o   = (state == WALK);
  assign amtIf.recoverDone_o   = (state == DONE);
  assign amtIf.recoverValid_o  = recValid;
  assign amtIf.recoverLog_o    = recLog;
  assign amtIf.recoverPhys_o   = recPhys;

endmodule

// File: tb/tb_arch_map_table_param.sv
// Bench for arch_map_table_param: a default-parameter instance (A: 4-wide
// commit, 34 entries) and a 2-wide / 32-entry instance (B) for the
// reset-mid-walk and exact-multiple walk cases.
module tb_arch_map_table_param;
  import amt_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  arch_map_table_param_if #(.COMMIT_WIDTH(4), .NUM_LOG_REGS(34), .PHYS_W(7), .RECOVER_WIDTH(4)) ifA ();
  arch_map_table_param_if #(.COMMIT_WIDTH(2), .NUM_LOG_REGS(32), .PHYS_W(7), .RECOVER_WIDTH(4)) ifB ();

  arch_map_table_param #(.COMMIT_WIDTH(4), .NUM_LOG_REGS(34), .PHYS_W(7), .RECOVER_WIDTH(4))
    dutA (.clk(clk), .reset(reset), .amtIf(ifA));
  arch_map_table_param #(.COMMIT_WIDTH(2), .NUM_LOG_REGS(32), .PHYS_W(7), .RECOVER_WIDTH(4))
    dutB (.clk(clk), .reset(reset), .amtIf(ifB));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]      cv;
    logic [3:0][5:0] lg;
    logic [3:0][6:0] ph;
    logic [3:0]      expV;
    logic [3:0][6:0] expP;
    logic [3:0]      pMask;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] cv,
                              input int l0, input int l1, input int l2, input int l3,
                              input int p0, input int p1, input int p2, input int p3,
                              input logic [3:0] ev,
                              input int e0, input int e1, input int e2, input int e3,
                              input logic [3:0] pm);
    vec_t v;
    v.cv = cv;
    v.lg[0] = 6'(l0); v.lg[1] = 6'(l1); v.lg[2] = 6'(l2); v.lg[3] = 6'(l3);
    v.ph[0] = 7'(p0); v.ph[1] = 7'(p1); v.ph[2] = 7'(p2); v.ph[3] = 7'(p3);
    v.expV = ev;
    v.expP[0] = 7'(e0); v.expP[1] = 7'(e1); v.expP[2] = 7'(e2); v.expP[3] = 7'(e3);
    v.pMask = pm;
    return v;
  endfunction

  task automatic clearA();
    ifA.commitValid_i = '0;
    ifA.commitLog_i   = '0;
    ifA.commitPhys_i  = '0;
    ifA.recoverReq_i  = 1'b0;
  endtask

  task automatic clearB();
    ifB.commitValid_i = '0;
    ifB.commitLog_i   = '0;
    ifB.commitPhys_i  = '0;
    ifB.recoverReq_i  = 1'b0;
  endtask

  // Full recovery walk on A, called at a negedge with inputs idle.
  // sameCommit: commit L3->P50 in the recoverReq cycle.
  // dropTest  : commit L3->P99 plus a second recoverReq mid-walk.
  task automatic walkA(input string tag, input int expT[34],
                       input bit sameCommit, input bit dropTest);
    int cyc;
    int idx;
    ifA.recoverReq_i = 1'b1;
    if (sameCommit) begin
      ifA.commitValid_i = 4'b0001;
      ifA.commitLog_i   = 24'(3);
      ifA.commitPhys_i  = 28'(50);
    end
    @(negedge clk);
    clearA();
    cyc = 0;
    while (ifA.recoverBusy_o && cyc < 50) begin
      for (int r = 0; r < 4; r++) begin
        idx = cyc * 4 + r;
        chk($sformatf("%s g%0d lane%0d valid", tag, cyc, r), int'(ifA.recoverValid_o[r]), int'(idx < 34));
        if (idx < 34) begin
          chk($sformatf("%s g%0d lane%0d log", tag, cyc, r), int'(ifA.recoverLog_o[r*6 +: 6]), idx);
          chk($sformatf("%s g%0d lane%0d phys", tag, cyc, r), int'(ifA.recoverPhys_o[r*7 +: 7]), expT[idx]);
        end
      end
      if (dropTest && cyc == 2) begin
        ifA.commitValid_i = 4'b0001;
        ifA.commitLog_i   = 24'(3);
        ifA.commitPhys_i  = 28'(99);
        ifA.recoverReq_i  = 1'b1;
      end
      @(negedge clk);
      if (dropTest && cyc == 2) begin
        clearA();
        chk({tag, " dropped pulse"}, int'(ifA.commitDropped_o), 1);
        chk({tag, " dropped relValid"}, int'(ifA.releasedValid_o), 0);
      end
      cyc++;
    end
    chk({tag, " walk cycles"}, cyc, numGroups(34, 4));
    chk({tag, " done pulse"}, int'(ifA.recoverDone_o), 1);
    chk({tag, " done busy"}, int'(ifA.recoverBusy_o), 0);
    chk({tag, " done recValid"}, int'(ifA.recoverValid_o), 0);
    @(negedge clk);
    chk({tag, " done cleared"}, int'(ifA.recoverDone_o), 0);
    chk({tag, " idle dropped"}, int'(ifA.commitDropped_o), 0);
  endtask

  vec_t vecs[7];
  int   idT[34];
  int   expA[34];
  int   cycB;
  bit   lanesOk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clearA();
    clearB();
    for (int i = 0; i < 34; i++) begin
      idT[i]  = i;
      expA[i] = i;
    end

    vecs[0] = mk(4'b1111, 5, 6, 5, 9,  40, 41, 42, 43, 4'b1111, 40, 6, 5, 9,   4'b1111);
    vecs[1] = mk(4'b0001, 5, 0, 0, 0,  50, 0, 0, 0,    4'b0001, 42, 0, 0, 0,   4'b1111);
    vecs[2] = mk(4'b1111, 7, 7, 7, 7,  60, 61, 62, 63, 4'b1111, 60, 61, 62, 7, 4'b1111);
    vecs[3] = mk(4'b0110, 1, 9, 9, 2,  70, 71, 72, 73, 4'b0110, 0, 71, 43, 0,  4'b1111);
    vecs[4] = mk(4'b0000, 5, 6, 7, 9,  1, 2, 3, 4,     4'b0000, 0, 0, 0, 0,    4'b1111);
    vecs[5] = mk(4'b0011, 40, 33, 0, 0, 80, 81, 0, 0,  4'b0011, 0, 33, 0, 0,   4'b1110);
    vecs[6] = mk(4'b1001, 0, 0, 0, 0,  91, 0, 0, 90,   4'b1001, 91, 0, 0, 0,   4'b1111);
    expA[0] = 90; expA[5] = 50; expA[6] = 41; expA[7] = 63; expA[9] = 72; expA[33] = 81;

    // Reset state
    #22;
    chk("reset relValid", int'(ifA.releasedValid_o), 0);
    chk("reset relPhys", int'(ifA.releasedPhys_o), 0);
    chk("reset busy", int'(ifA.recoverBusy_o), 0);
    chk("reset done", int'(ifA.recoverDone_o), 0);
    chk("reset recValid", int'(ifA.recoverValid_o), 0);
    chk("reset dropped", int'(ifA.commitDropped_o), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    walkA("identity", idT, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      ifA.commitValid_i = vecs[i].cv;
      ifA.commitLog_i   = vecs[i].lg;
      ifA.commitPhys_i  = vecs[i].ph;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("vec%0d relValid%0d", i, k), int'(ifA.releasedValid_o[k]), int'(vecs[i].expV[k]));
        if (vecs[i].pMask[k])
          chk($sformatf("vec%0d relPhys%0d", i, k), int'(ifA.releasedPhys_o[k*7 +: 7]), int'(vecs[i].expP[k]));
      end
    end
    clearA();
    @(negedge clk);
    chk("idle relValid", int'(ifA.releasedValid_o), 0);

    walkA("commits", expA, 1'b0, 1'b0);
    walkA("dropwalk", expA, 1'b0, 1'b1);
    walkA("afterdrop", expA, 1'b0, 1'b0);
    expA[3] = 50;
    walkA("samecycle", expA, 1'b1, 1'b0);

    // Lane 2 invalid: lane 0 is no longer squashed
    reset = 1'b0;
    #1;
    chk("reset2 busy", int'(ifA.recoverBusy_o), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ifA.commitValid_i = 4'b1011;
    ifA.commitLog_i   = {6'd9, 6'd5, 6'd6, 6'd5};
    ifA.commitPhys_i  = {7'd43, 7'd42, 7'd41, 7'd40};
    @(negedge clk);
    clearA();
    chk("nosq relValid", int'(ifA.releasedValid_o), 4'b1011);
    chk("nosq relPhys0", int'(ifA.releasedPhys_o[0 +: 7]), 5);
    chk("nosq relPhys1", int'(ifA.releasedPhys_o[7 +: 7]), 6);
    chk("nosq relPhys2", int'(ifA.releasedPhys_o[14 +: 7]), 0);
    chk("nosq relPhys3", int'(ifA.releasedPhys_o[21 +: 7]), 9);
    for (int i = 0; i < 34; i++) expA[i] = i;
    expA[5] = 40; expA[6] = 41; expA[9] = 43;
    walkA("nosq", expA, 1'b0, 1'b0);

    // Instance B: reset in walk cycle 3, then a clean identity walk
    ifB.commitValid_i = 2'b01;
    ifB.commitLog_i   = 10'(4);
    ifB.commitPhys_i  = 14'(100);
    @(negedge clk);
    clearB();
    ifB.recoverReq_i = 1'b1;
    @(negedge clk);
    ifB.recoverReq_i = 1'b0;
    chk("B walk1 lane0 phys4", int'(ifB.recoverPhys_o[0 +: 7]), 0);
    @(negedge clk);
    chk("B walk1 g1 lane0 phys", int'(ifB.recoverPhys_o[0 +: 7]), 100);
    @(negedge clk);
    chk("B walk1 busy at cycle3", int'(ifB.recoverBusy_o), 1);
    reset = 1'b0;
    #1;
    chk("B midreset busy", int'(ifB.recoverBusy_o), 0);
    chk("B midreset recValid", int'(ifB.recoverValid_o), 0);
    chk("B midreset done", int'(ifB.recoverDone_o), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("B post-reset idle busy", int'(ifB.recoverBusy_o), 0);
    ifB.recoverReq_i = 1'b1;
    @(negedge clk);
    ifB.recoverReq_i = 1'b0;
    cycB = 0;
    lanesOk = 1'b1;
    while (ifB.recoverBusy_o && cycB < 50) begin
      for (int r = 0; r < 4; r++) begin
        if (ifB.recoverValid_o[r] !== 1'b1 ||
            int'(ifB.recoverLog_o[r*5 +: 5]) != cycB * 4 + r ||
            int'(ifB.recoverPhys_o[r*7 +: 7]) != cycB * 4 + r)
          lanesOk = 1'b0;
      end
      @(negedge clk);
      cycB++;
    end
    chk("B walk2 lanes identity", int'(lanesOk), 1);
    chk("B walk2 cycles", cycB, 8);
    chk("B walk2 done", int'(ifB.recoverDone_o), 1);
    @(negedge clk);
    chk("B walk2 done cleared", int'(ifB.recoverDone_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arch_map_table_param.md
Name: arch_map_table_param

Overview:
- Parametrised architectural map table (AMT). Sits between the ActiveList commit stage and the rename map table (RMT) / speculative free list.
- On commit, it records the newest logical-to-physical mapping per logical register and releases the superseded physical register.
- On a recovery request, it walks the whole table and streams the mappings to the RMT, RECOVER_WIDTH entries per cycle, under a start/busy/done handshake.
- Generalises the fixed 4-wide AMT:
  - commit width and table depth are arbitrary;
  - the last recovery group may be partial and carries per-lane valid bits;
  - released mappings are registered;
  - the recovery walk is a sequenced FSM.

Parameters:
- COMMIT_WIDTH, 4, committing instructions per cycle (1..8).
- NUM_LOG_REGS, 34, logical registers / AMT entries; need not be a multiple of RECOVER_WIDTH.
- PHYS_W, 7, physical register tag width.
- RECOVER_WIDTH, 4, entries sent to the RMT per recovery cycle (1..8).
- LOG_W, localparam = $clog2(NUM_LOG_REGS).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- commitValid_i  in  COMMIT_WIDTH  lane k retires an instruction with a destination; lane 0 is oldest.
- commitLog_i  in  COMMIT_WIDTH*LOG_W  logical destination per lane.
- commitPhys_i  in  COMMIT_WIDTH*PHYS_W  new physical destination per lane.
- recoverReq_i  in  1  one-cycle pulse from ActiveList: exception or mispredict.
- releasedValid_o  out  COMMIT_WIDTH  registered release valids.
- releasedPhys_o  out  COMMIT_WIDTH*PHYS_W  registered released tags.
- recoverBusy_o  out  1  walk in progress.
- recoverValid_o  out  RECOVER_WIDTH  per-lane valid of the recovery packet.
- recoverLog_o  out  RECOVER_WIDTH*LOG_W  logical index per recovery lane.
- recoverPhys_o  out  RECOVER_WIDTH*PHYS_W  mapping per recovery lane.
- recoverDone_o  out  1  one-cycle pulse on the cycle after the last group.
- commitDropped_o  out  1  one-cycle pulse: a commit arrived while busy and was ignored.

Behaviour:
Reset
- Table entry i = i (i < NUM_LOG_REGS); state IDLE.
- All outputs 0.

Commit (state IDLE only)
- Lane k is squashed (no table write) if any younger valid lane j > k has the same commitLog.
- Squashed lane: released tag = its own commitPhys.
- Non-squashed lane: released tag = table[commitLog_k] read before this cycle's writes.
- Non-squashed valid lanes write table[commitLog_k] = commitPhys_k at the clock edge. Write addresses are unique by construction.
- releasedValid_o[k] = commitValid_i[k], registered: 1-cycle latency. releasedPhys_o is registered with it.
- Invalid lanes: releasedValid 0; their releasedPhys is don't-care but driven 0.
- commitLog >= NUM_LOG_REGS is illegal; the write is suppressed and the release valid is still driven.

Recovery FSM: IDLE -> WALK -> DONE -> IDLE
- IDLE: recoverReq_i=1 -> WALK, ptr=0. Commits in the same cycle as recoverReq are applied first.
- WALK:
  - recoverBusy_o=1.
  - Lane r output is combinational from the table: index ptr+r, valid iff ptr+r < NUM_LOG_REGS, phys = table[ptr+r].
  - ptr += RECOVER_WIDTH each cycle. When ptr+RECOVER_WIDTH >= NUM_LOG_REGS, the next state is DONE.
  - Number of walk cycles = ceil(NUM_LOG_REGS/RECOVER_WIDTH).
- DONE: recoverDone_o=1 for one cycle, busy 0, recoverValid 0 -> IDLE.
- Valid lanes never carry out-of-range indices. No wrap-around reuse: ptr compares against the exact bound, not a power of two.
- recoverReq_i during WALK/DONE: ignored; the walk is not restarted.
- commitValid_i != 0 during WALK/DONE: no table write, no release, commitDropped_o pulses next cycle.
- Reset mid-walk: immediately IDLE, table reinitialised to identity, outputs 0.
- Outside WALK, recoverValid_o = 0 and recoverLog/Phys = 0.

Decomposition:
- Shared package amt_pkg: width helper functions (log2), and packet field extraction functions for lane slicing of the flat buses.
- One sub-module: amt_waw_squash (combinational). Takes commitValid and commitLog, produces the squash vector. Reusable by the free-list release logic.
- Table storage stays inline as a flop array: multi-read, multi-write, with reset initialisation.

Test Plan:
- Reset with defaults -> walk after recoverReq gives 9 cycles. Groups 0-3 ... 32-33. Last group valid = 4'b0011. Lane 1 of the last group = {33, phys 33}. recoverDone pulses in cycle 10.
- Commit lanes 0..3 = {L5->P40, L6->P41, L5->P42, L9->P43}, all valid:
  - cycle+1: releasedValid=4'b1111, releasedPhys = {P40 (squashed), P6, P5, P9}.
  - Table afterwards: L5=P42, L6=P41, L9=P43.
- Same as above but lane 2 invalid -> lane 0 is not squashed. Lane 0 releases P5 and L5=P40.
- recoverReq pulse with commit L3->P50 in the same cycle -> first recovery group shows L3=P50.
- Commit during WALK -> commitDropped_o=1 next cycle, releasedValid=0, and the table is unchanged (verified by a second walk).
- NUM_LOG_REGS=32, RECOVER_WIDTH=4, COMMIT_WIDTH=2: assert reset at walk cycle 3 -> busy drops immediately. A post-reset walk shows the identity map over exactly 8 cycles with all lanes valid.
